// File: rtl/svc_rv_soc_run_ctrl.sv
// Run controller for the BRAM RISC-V SoC demo.
// Sequences SoC reset, times runs to ebreak, aborts runaways.
module svc_rv_soc_run_ctrl #(
  parameter int CYCLE_W    = 32,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 1000000,
  parameter bit AUTO_START = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               ebreak,
  output logic               soc_rst_n,
  output logic               running,
  output logic               done,
  output logic               timeout,
  output logic [CYCLE_W-1:0] cycles,
  output logic [7:0]         run_count
);

  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_DONE,
    S_TMO
  } state_t;

  localparam state_t S_INIT = AUTO_START ? S_HOLD : S_IDLE;

  state_t state, state_nx;

  logic [HW-1:0]      hold_cnt, hold_cnt_d;
  logic [CYCLE_W-1:0] cnt, cnt_d, cnt_inc;
  logic [CYCLE_W-1:0] cycles_d;
  logic [7:0]         run_count_d;
  logic               soc_rst_n_d;
  logic               running_d;
  logic               done_d;
  logic               timeout_d;
  logic               hold_last;
  logic               finish;

  assign cnt_inc   = cnt + 1'b1;
  assign hold_last = (hold_cnt == HW'(RST_CYCLES - 1));

  // State, counters and every output are flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      hold_cnt  <= '0;
      cnt       <= '0;
      soc_rst_n <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cycles    <= '0;
      run_count <= '0;
    end else begin
      state     <= state_nx;
      hold_cnt  <= hold_cnt_d;
      cnt       <= cnt_d;
      soc_rst_n <= soc_rst_n_d;
      running   <= running_d;
      done      <= done_d;
      timeout   <= timeout_d;
      cycles    <= cycles_d;
      run_count <= run_count_d;
    end
  end

  // Next state: ebreak takes priority over timeout in RUN.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_HOLD;
      S_HOLD: if (hold_last) state_nx = S_RUN;
      S_RUN: begin
        if (ebreak) state_nx = S_DONE;
        else if (cnt_inc == CYCLE_W'(TIMEOUT)) state_nx = S_TMO;
      end
      S_DONE: if (start) state_nx = S_HOLD;
      S_TMO:  if (start) state_nx = S_HOLD;
      default: state_nx = S_IDLE;
    endcase
  end

  // Register inputs derived from the upcoming state.
  always_comb begin
    finish      = (state == S_RUN) && (state_nx != S_RUN);
    soc_rst_n_d = (state_nx == S_RUN) || (state_nx == S_DONE) ||
                  (state_nx == S_TMO);
    running_d   = (state_nx == S_RUN);
    done_d      = (state_nx == S_DONE);
    timeout_d   = (state_nx == S_TMO);
    hold_cnt_d  = '0;
    if ((state == S_HOLD) && (state_nx == S_HOLD))
      hold_cnt_d = hold_cnt + 1'b1;
    cnt_d = '0;
    if ((state == S_RUN) && (state_nx == S_RUN))
      cnt_d = cnt_inc;
    cycles_d = cycles;
    if (finish)
      cycles_d = cnt_inc;
    run_count_d = run_count;
    if (finish && (run_count != 8'hFF))
      run_count_d = run_count + 8'd1;
  end

endmodule

// File: doc/svc_rv_soc_run_ctrl.md
Name: svc_rv_soc_run_ctrl

Overview:
Run controller that sits directly upstream of the BRAM RISC-V SoC demo top and consumes its ebreak. It sequences the SoC's reset, measures the number of clock cycles from reset release to ebreak, and detects runaway programs with a timeout. It supports re-running the program on a start pulse, so board LEDs and the bench can observe the result and the cycle count.

Parameters:
CYCLE_W, 32, width of cycle counter and latched result
RST_CYCLES, 4, cycles soc_rst_n is held low per run (>=1)
TIMEOUT, 1000000, max RUN cycles before abort (>=1, < 2**CYCLE_W)
AUTO_START, 1, 1: begin a run automatically after rst_n deasserts; 0: wait in IDLE for start

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to (re)run the program
ebreak  input  1  ebreak from SoC, synchronous to clk
soc_rst_n  output  1  active-low reset driven to the SoC
running  output  1  high while in RUN
done  output  1  high in DONE (program hit ebreak)
timeout  output  1  high in TIMEOUT (no ebreak within TIMEOUT cycles)
cycles  output  CYCLE_W  latched RUN-cycle count of the last finished run
run_count  output  8  number of completed runs (DONE or TIMEOUT), saturating

Behaviour:
- Reset: one clock, clk; rst_n asynchronous active-low. On reset: state = HOLD if AUTO_START else IDLE; soc_rst_n=0, running=0, done=0, timeout=0, cycles=0, run_count=0, hold counter=0, run counter=0.
- All outputs are registered (flops); soc_rst_n is a flop output, never combinational.
- States: IDLE, HOLD, RUN, DONE, TIMEOUT.
- IDLE: soc_rst_n=0. Sampling start=1 -> HOLD.
- HOLD: soc_rst_n=0 for exactly RST_CYCLES cycles, with the hold counter cleared on entry. After RST_CYCLES cycles -> RUN; soc_rst_n goes 1 and running goes 1 on the same edge; the run counter is cleared.
- RUN: run counter cnt increments each cycle.
  - ebreak=1 sampled in RUN -> DONE, cycles <= cnt+1. An ebreak on the first RUN cycle gives cycles=1.
  - Otherwise, if cnt+1 == TIMEOUT -> TIMEOUT, cycles <= TIMEOUT.
  - ebreak and timeout in the same cycle: DONE wins.
- DONE / TIMEOUT: soc_rst_n stays 1 (SoC left running for inspection). done or timeout held high; running=0. run_count += 1 on entry, saturating at 255.
- start=1 in DONE, TIMEOUT or IDLE -> HOLD. done and timeout clear on the HOLD entry edge. cycles keeps its last value until the next run finishes.
- start in HOLD or RUN: ignored (no restart, no extension of HOLD).
- ebreak outside RUN: ignored, including while the SoC is held in reset.
- done, timeout and running are mutually exclusive at all times.
- rst_n asserted mid-run: immediate asynchronous return to the reset values; soc_rst_n drops in the same cycle without waiting for an edge.
- cnt width is CYCLE_W; it cannot wrap because TIMEOUT < 2**CYCLE_W.

Test Plan:
1. AUTO_START=1, RST_CYCLES=4: release rst_n, drive ebreak high at RUN cycle 100 -> soc_rst_n low for exactly 4 cycles; running for 100 cycles; then done=1, cycles=100, run_count=1, soc_rst_n stays 1.
2. TIMEOUT=50, ebreak never asserted -> timeout=1 after 50 RUN cycles, cycles=50, done=0, run_count=1. Variant with ebreak on RUN cycle 50 -> done=1, timeout=0, cycles=50.
3. After DONE, pulse start; ebreak at RUN cycle 7 -> done clears on the HOLD entry edge, 4-cycle HOLD, then done=1, cycles=7, run_count=2. Pulse start during HOLD and RUN -> no effect on timing.
4. AUTO_START=0 -> stays in IDLE with soc_rst_n=0 and ebreak toggled freely, all status 0. Pulse start -> normal HOLD/RUN sequence follows.
5. Assert rst_n low mid-RUN between edges -> soc_rst_n, running and cycles go 0 asynchronously. Release -> a fresh run starts with cycles counted from 1.
6. Force 256 runs with TIMEOUT=2 -> run_count saturates at 255 and does not wrap.
